// File: rtl/mdu_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MUL   = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic do_neg);
    return do_neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// One radix-2 restoring division step on the {remainder, quotient} pair.
module div_iter
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_div};

  // A zero divisor always subtracts, giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    o_rem = w_shift[XLEN-1:0];
    o_quo = {i_quo[XLEN-2:0], 1'b0};
    if (w_shift >= {1'b0, i_div}) begin
      o_rem = w_diff[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end else begin
      o_rem = w_shift[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module hilo_mdu
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_t      r_state, w_state_nxt;
  mdu_op_t         w_op;
  logic [XLEN-1:0] r_opa, r_opb, r_rem, r_quo, r_hi, r_lo;
  logic [4:0]      r_cnt;
  logic            r_mul_signed, r_sign_q, r_sign_r, r_res_valid;
  logic            w_accept, w_hi_we, w_lo_we, w_res_nxt;
  logic [XLEN-1:0] w_hi_nxt, w_lo_nxt, w_rem_step, w_quo_step;
  logic [63:0]     w_ext_a, w_ext_b, w_prod;

  assign w_op      = mdu_op_t'(req_op);
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = req_valid & req_ready & ~flush;
  assign res_valid = r_res_valid;
  assign hi        = r_hi;
  assign lo        = r_lo;

  // Sign- or zero-extending both operands lets one 64-bit multiply serve mult and multu.
  assign w_ext_a = r_mul_signed ? {{32{r_opa[31]}}, r_opa} : {32'd0, r_opa};
  assign w_ext_b = r_mul_signed ? {{32{r_opb[31]}}, r_opb} : {32'd0, r_opb};
  assign w_prod  = w_ext_a * w_ext_b;

  div_iter u_div_iter (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_opb),
    .o_rem (w_rem_step),
    .o_quo (w_quo_step)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and HI/LO write decode; flush suppresses every write.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_res_nxt   = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            case (w_op)
              MDU_MULT, MDU_MULTU, MDU_MUL: w_state_nxt = MUL;
              MDU_DIV, MDU_DIVU:            w_state_nxt = DIV;
              MDU_MTHI: begin
                w_hi_we  = 1'b1;
                w_hi_nxt = srca;
              end
              MDU_MTLO: begin
                w_lo_we  = 1'b1;
                w_lo_nxt = srca;
              end
              default: w_state_nxt = IDLE;
            endcase
          end else begin
            w_state_nxt = IDLE;
          end
        end
        MUL: begin
          w_hi_we     = 1'b1;
          w_lo_we     = 1'b1;
          w_hi_nxt    = w_prod[63:32];
          w_lo_nxt    = w_prod[31:0];
          w_res_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
        DIV: begin
          if (r_cnt == 5'd31) w_state_nxt = FIX;
          else                w_state_nxt = DIV;
        end
        FIX: begin
          w_hi_we     = 1'b1;
          w_lo_we     = 1'b1;
          w_hi_nxt    = neg_if(r_rem, r_sign_r);
          w_lo_nxt    = neg_if(r_quo, r_sign_q);
          w_res_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture at acceptance, then one division step per DIV cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_opa        <= 32'd0;
      r_opb        <= 32'd0;
      r_rem        <= 32'd0;
      r_quo        <= 32'd0;
      r_cnt        <= 5'd0;
      r_mul_signed <= 1'b0;
      r_sign_q     <= 1'b0;
      r_sign_r     <= 1'b0;
    end else if (w_accept) begin
      case (w_op)
        MDU_MULT, MDU_MUL, MDU_MULTU: begin
          r_opa        <= srca;
          r_opb        <= srcb;
          r_mul_signed <= (w_op != MDU_MULTU);
        end
        MDU_DIV, MDU_DIVU: begin
          r_quo    <= abs_val(srca, w_op == MDU_DIV);
          r_opb    <= abs_val(srcb, w_op == MDU_DIV);
          r_rem    <= 32'd0;
          r_cnt    <= 5'd0;
          r_sign_q <= (w_op == MDU_DIV) & (srca[31] ^ srcb[31]);
          r_sign_r <= (w_op == MDU_DIV) & srca[31];
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end else if ((r_state == DIV) && !flush) begin
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
      r_cnt <= r_cnt + 5'd1;
    end
  end

  // Architectural HI/LO and the completion pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_nxt;
      if (w_lo_we) r_lo <= w_lo_nxt;
      r_res_valid <= w_res_nxt;
    end
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multiply/divide unit and HI/LO register owner for the MIPS core. It accepts mult/multu/mul/div/divu/mthi/mtlo requests from the execute stage and performs them multi-cycle. It holds the architectural HI/LO pair, which the ALU reads for mfhi/mflo/mul. The pipeline stalls on `busy`, and `flush` cancels in-flight work on an exception.

## Interface
Parameters:
- none; width fixed at 32.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  execute stage presents an MDU instruction.
- `req_ready`  out  1  high when the unit can accept a request.
- `req_op`  in  3  `mdu_op_t` operation.
- `srca`  in  32  rs value; dividend or multiplicand.
- `srcb`  in  32  rt value; divisor or multiplier.
- `flush`  in  1  cancel any in-flight operation; drop any request in the same cycle.
- `busy`  out  1  an operation is in flight; HI/LO are not yet final.
- `res_valid`  out  1  one-cycle pulse in the cycle after HI/LO are written by mult/div.
- `hi`  out  32  architectural HI, register output.
- `lo`  out  32  architectural LO, register output.

## Operation
- Accept condition: `req_valid & req_ready & !flush` at an edge E0.
  - `req_ready = (state==IDLE)`.
- States:
  - IDLE
  - MUL
  - DIV
  - FIX
- `mthi` / `mtlo` at E0:
  - write `srca` to HI or LO.
  - stay in IDLE; `busy` stays 0; no `res_valid`.
- `mult` / `multu` / `mul` at E0:
  - register operands; go to MUL.
  - at E1, write the 64-bit product: HI = [63:32], LO = [31:0]; return to IDLE.
  - `mult` / `mul` multiply as signed; `multu` as unsigned.
- `div` / `divu` at E0:
  - register |a|, |b| (raw values for divu), sign_q = sa^sb, sign_r = sa; clear 5-bit counter; go to DIV.
  - one radix-2 restoring step per cycle, 32 steps (E1..E32); counter wraps 31->0 and moves to FIX.
  - at E33, FIX negates quotient if sign_q and remainder if sign_r; writes LO = quotient, HI = remainder; returns to IDLE.
- Divide by zero is deterministic:
  - unsigned magnitude result is q = 0xFFFFFFFF, r = |a|; sign fixup then applies.
- Overflow case 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- `flush`:
  - in any state, next state is IDLE and HI/LO keep their values.
  - `flush` overrides a write due at the same edge.
  - no `res_valid`.
- Illegal `req_op` codes (7) are accepted as a no-op and stay in IDLE.

## Timing
- Reset values:
  - state = IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `res_valid` = 0.
  - `req_ready` = 1.
- Reset mid-operation aborts immediately; asynchronous reset takes priority over everything.
- `busy = (state != IDLE)`.
  - Multiply: high for exactly 1 cycle (E0..E1).
  - Divide: high for 33 cycles (E0..E33).
- New HI/LO values are visible on `hi`/`lo` in the cycle after the write edge.
  - mthi/mtlo: the cycle after E0.
  - mult: the cycle after E1.
  - div: the cycle after E33.
- No internal forwarding. An mfhi immediately following mthi sees the new value only if issued after the write edge; the pipeline guarantees this via `busy`/ordering.
- Back-to-back: a new request is accepted in the same cycle `res_valid` is high.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op_t`: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MUL=6.
  - `mdu_state_t`: IDLE, MUL, DIV, FIX.
- Sub-module `div_iter`:
  - combinational single restoring step, taking {remainder, quotient} and divisor and returning the next pair.
  - the top level instantiates it once inside the iteration loop.

## Test plan
- mult 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE one cycle after E1. multu of the same operands -> HI=0x00000001, LO=0xFFFFFFFE. `busy` high 1 cycle; `res_valid` pulses once.
- div -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) after E33; divu 100 / 7 -> LO=14, HI=2; `busy` high exactly 33 cycles.
- divu 7 / 0 -> LO=0xFFFFFFFF, HI=7. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x12345678 then mtlo 0xCAFEBABE on consecutive cycles -> `hi`/`lo` hold those values; `busy` never asserts.
- Start div; assert `flush` at cycle 10 -> IDLE next cycle, HI/LO unchanged, no `res_valid`. Separately, `flush` in the same cycle as a `req_valid` mult -> request not accepted.
- Deassert `resetn` during DIV -> immediately `busy`=0, `hi`=`lo`=0; after release, a mult 3 x 5 gives LO=15, HI=0.
